// File: rtl/i2c_tmp101_responder.sv
// I2C target modelling a TMP101 sensor: decodes its address, keeps a pointer and
// configuration register, and serves temperature or configuration bytes on reads.
module i2c_tmp101_responder #(
  parameter logic [6:0] SLAVE_ADDR   = 7'b1001000,
  parameter logic [7:0] CONFIG_RESET = 8'h00
) (
  input  logic        CLOCK,
  input  logic        Reset,
  input  logic        SCL,
  input  logic        SDA,
  output logic        SDA_Low,
  input  logic [11:0] Temperature,
  output logic [1:0]  Pointer,
  output logic [7:0]  Config,
  output logic        Busy
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE
  } StateType;

  logic [1:0] sclSync, sdaSync;
  logic       sclPrev, sdaPrev;
  logic       sclNow, sdaNow;
  logic       sclRise, sclFall, startCond, stopCond;

  StateType    state, stateNext;
  logic [2:0]  bitCnt, bitCntNext;
  logic [6:0]  shiftReg, shiftNext;
  logic [6:0]  txByte, txNext;
  logic [1:0]  phase, phaseNext;
  logic        readDir, readDirNext;
  logic        firstByte, firstNext;
  logic        sendLsb, sendLsbNext;
  logic [11:0] snapshot, snapshotNext;
  logic        sdaLowReg, sdaLowNext;
  logic        busyReg, busyNext;
  logic [1:0]  pointerReg, pointerNext;
  logic [7:0]  configReg, configNext;
  logic [7:0]  rxByte, readByte;
  logic        loadRead;

  // Pins are asynchronous; sync flops reset to the idle-bus level so reset
  // itself never manufactures a START.
  always_ff @(posedge CLOCK) begin
    if (Reset) begin
      sclSync <= 2'b11;
      sdaSync <= 2'b11;
      sclPrev <= 1'b1;
      sdaPrev <= 1'b1;
    end else begin
      sclSync <= {sclSync[0], SCL};
      sdaSync <= {sdaSync[0], SDA};
      sclPrev <= sclSync[1];
      sdaPrev <= sdaSync[1];
    end
  end

  assign sclNow    = sclSync[1];
  assign sdaNow    = sdaSync[1];
  assign sclRise   = sclNow & ~sclPrev;
  assign sclFall   = ~sclNow & sclPrev;
  assign startCond = sclNow & sclPrev & sdaPrev & ~sdaNow;
  assign stopCond  = sclNow & sclPrev & ~sdaPrev & sdaNow;
  assign rxByte    = {shiftReg, sdaNow};

  always_comb begin
    readByte = 8'h00;
    if (pointerReg == 2'b00)
      readByte = sendLsb ? {snapshot[3:0], 4'h0} : snapshot[11:4];
    else if (pointerReg == 2'b01)
      readByte = configReg;
  end

  // ACK states use phase 0 = waiting for the fall that starts our drive,
  // 1 = driving; RD_ACK adds phase 2 = master ACKed, next byte on the fall.
  always_comb begin
    stateNext    = state;
    bitCntNext   = bitCnt;
    shiftNext    = shiftReg;
    txNext       = txByte;
    phaseNext    = phase;
    readDirNext  = readDir;
    firstNext    = firstByte;
    sendLsbNext  = sendLsb;
    snapshotNext = snapshot;
    sdaLowNext   = sdaLowReg;
    busyNext     = busyReg;
    pointerNext  = pointerReg;
    configNext   = configReg;
    loadRead     = 1'b0;

    if (stopCond) begin
      stateNext  = IDLE;
      sdaLowNext = 1'b0;
      busyNext   = 1'b0;
    end else if (startCond) begin
      stateNext  = ADDR;
      bitCntNext = 3'd0;
      sdaLowNext = 1'b0;
      busyNext   = 1'b0;
    end else begin
      case (state)
        ADDR: begin
          if (sclRise) begin
            shiftNext  = rxByte[6:0];
            bitCntNext = bitCnt + 3'd1;
            if (bitCnt == 3'd7) begin
              if (rxByte[7:1] == SLAVE_ADDR) begin
                stateNext    = ADDR_ACK;
                busyNext     = 1'b1;
                snapshotNext = Temperature;
                readDirNext  = rxByte[0];
                firstNext    = 1'b1;
                sendLsbNext  = 1'b0;
                phaseNext    = 2'd0;
              end else begin
                stateNext = IGNORE;
              end
            end
          end
        end
        ADDR_ACK, WR_ACK: begin
          if (sclFall) begin
            if (phase == 2'd0) begin
              sdaLowNext = 1'b1;
              phaseNext  = 2'd1;
            end else if (state == ADDR_ACK && readDir) begin
              loadRead = 1'b1;
            end else begin
              stateNext  = WR_BYTE;
              bitCntNext = 3'd0;
              sdaLowNext = 1'b0;
            end
          end
        end
        WR_BYTE: begin
          if (sclRise) begin
            shiftNext  = rxByte[6:0];
            bitCntNext = bitCnt + 3'd1;
            if (bitCnt == 3'd7) begin
              stateNext = WR_ACK;
              phaseNext = 2'd0;
              if (firstByte) begin
                pointerNext = rxByte[1:0];
                firstNext   = 1'b0;
              end else if (pointerReg == 2'b01) begin
                configNext = rxByte;
              end
            end
          end
        end
        RD_BYTE: begin
          if (sclRise) begin
            bitCntNext = bitCnt + 3'd1;
            if (bitCnt == 3'd7) begin
              stateNext = RD_ACK;
              phaseNext = 2'd0;
            end
          end else if (sclFall) begin
            txNext     = {txByte[5:0], 1'b0};
            sdaLowNext = ~txByte[6];
          end
        end
        RD_ACK: begin
          if (sclFall) begin
            if (phase == 2'd0) begin
              sdaLowNext = 1'b0;
              phaseNext  = 2'd1;
            end else if (phase == 2'd2) begin
              loadRead = 1'b1;
            end
          end else if (sclRise && phase == 2'd1) begin
            if (!sdaNow) phaseNext = 2'd2;
            else         stateNext = IGNORE;
          end
        end
        default: ;
      endcase
    end

    if (loadRead) begin
      stateNext   = RD_BYTE;
      bitCntNext  = 3'd0;
      txNext      = readByte[6:0];
      sdaLowNext  = ~readByte[7];
      sendLsbNext = ~sendLsb;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (Reset) begin
      state      <= IDLE;
      bitCnt     <= 3'd0;
      shiftReg   <= 7'd0;
      txByte     <= 7'd0;
      phase      <= 2'd0;
      readDir    <= 1'b0;
      firstByte  <= 1'b0;
      sendLsb    <= 1'b0;
      snapshot   <= 12'd0;
      sdaLowReg  <= 1'b0;
      busyReg    <= 1'b0;
      pointerReg <= 2'b00;
      configReg  <= CONFIG_RESET;
    end else begin
      state      <= stateNext;
      bitCnt     <= bitCntNext;
      shiftReg   <= shiftNext;
      txByte     <= txNext;
      phase      <= phaseNext;
      readDir    <= readDirNext;
      firstByte  <= firstNext;
      sendLsb    <= sendLsbNext;
      snapshot   <= snapshotNext;
      sdaLowReg  <= sdaLowNext;
      busyReg    <= busyNext;
      pointerReg <= pointerNext;
      configReg  <= configNext;
    end
  end

  assign SDA_Low = sdaLowReg;
  assign Busy    = busyReg;
  assign Pointer = pointerReg;
  assign Config  = configReg;

endmodule

// File: tb/tb_i2c_tmp101_responder.sv
// Bit-banged I2C master driving the TMP101 responder with directed and random
// transactions, checked against a transaction-level pointer/config/data model.
`timescale 1ns/1ps
module tb_i2c_tmp101_responder;

  localparam int Q = 6;

  logic        CLOCK = 1'b0;
  logic        Reset = 1'b1;
  logic        sclM = 1'b1;
  logic        sdaM = 1'b1;
  logic [11:0] Temperature = 12'h000;
  logic        SDA_Low, Busy;
  logic [1:0]  Pointer;
  logic [7:0]  Config;
  logic        sdaBus;

  assign sdaBus = sdaM & ~SDA_Low;

  i2c_tmp101_responder dut (
    .CLOCK(CLOCK), .Reset(Reset), .SCL(sclM), .SDA(sdaBus), .SDA_Low(SDA_Low),
    .Temperature(Temperature), .Pointer(Pointer), .Config(Config), .Busy(Busy)
  );

  always #5 CLOCK = ~CLOCK;

  int         vectors = 0;
  int         miscompares = 0;
  int         highChanges = 0;
  logic [1:0] modelPointer = 2'b00;
  logic [7:0] modelConfig = 8'h00;
  logic [7:0] wrBuf [3];
  logic       lowSeen = 1'b0;
  logic       lowPrev = 1'b0;
  logic       sclAtEdge, rstAtEdge;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // SDA_Low must only move while SCL is low, except on a reset edge.
  always @(posedge CLOCK) begin
    sclAtEdge = sclM;
    rstAtEdge = Reset;
    #1;
    if (SDA_Low) lowSeen = 1'b1;
    if (SDA_Low != lowPrev && sclAtEdge && !rstAtEdge) highChanges++;
    lowPrev = SDA_Low;
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic waitClk(input int n);
    repeat (n) @(negedge CLOCK);
  endtask

  task automatic startBit();
    sdaM = 1'b1; waitClk(Q);
    sclM = 1'b1; waitClk(Q);
    sdaM = 1'b0; waitClk(Q);
    sclM = 1'b0; waitClk(Q);
  endtask

  task automatic stopBit();
    sdaM = 1'b0; waitClk(Q);
    sclM = 1'b1; waitClk(Q);
    sdaM = 1'b1; waitClk(Q);
  endtask

  task automatic sendBit(input logic b);
    sdaM = b;    waitClk(Q);
    sclM = 1'b1; waitClk(2 * Q);
    sclM = 1'b0; waitClk(Q);
  endtask

  task automatic recvBit(output logic b);
    sdaM = 1'b1; waitClk(Q);
    sclM = 1'b1; waitClk(Q);
    b = sdaBus;  waitClk(Q);
    sclM = 1'b0; waitClk(Q);
  endtask

  task automatic sendByte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) sendBit(d[i]);
    recvBit(b);
    ack = ~b;
  endtask

  task automatic recvByte(output logic [7:0] d, input logic giveAck);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recvBit(b);
      d[i] = b;
    end
    sendBit(~giveAck);
  endtask

  // Expected byte idx of a read, from the pointer rules and the address-time snapshot.
  function automatic logic [7:0] expectedRead(input int idx, input logic [11:0] snap);
    case (modelPointer)
      2'b00:   return (idx % 2 == 0) ? snap[11:4] : {snap[3:0], 4'h0};
      2'b01:   return modelConfig;
      default: return 8'h00;
    endcase
  endfunction

  task automatic applyStimulusWrite(input logic [6:0] addr7, input int n, input bit doStop);
    logic ack, match;
    match = (addr7 == 7'h48);
    lowSeen = 1'b0;
    startBit();
    sendByte({addr7, 1'b0}, ack);
    checkOutput("writeAddrAck", 32'(ack), 32'(match));
    checkOutput("busyAfterWriteAddr", 32'(Busy), 32'(match));
    for (int i = 0; i < n; i++) begin
      sendByte(wrBuf[i], ack);
      checkOutput("writeDataAck", 32'(ack), 32'(match));
      if (match) begin
        if (i == 0) modelPointer = wrBuf[0][1:0];
        else if (modelPointer == 2'b01) modelConfig = wrBuf[i];
      end
    end
    if (!match) checkOutput("quietWhenUnaddressed", 32'(lowSeen), 32'd0);
    if (doStop) begin
      stopBit();
      checkOutput("busyAfterStop", 32'(Busy), 32'd0);
    end
    checkOutput("pointer", 32'(Pointer), 32'(modelPointer));
    checkOutput("config", 32'(Config), 32'(modelConfig));
  endtask

  task automatic applyStimulusRead(input logic [6:0] addr7, input int n);
    logic ack, match;
    logic [11:0] snap;
    logic [7:0] d;
    match = (addr7 == 7'h48);
    lowSeen = 1'b0;
    snap = Temperature;
    startBit();
    sendByte({addr7, 1'b1}, ack);
    checkOutput("readAddrAck", 32'(ack), 32'(match));
    checkOutput("busyAfterReadAddr", 32'(Busy), 32'(match));
    for (int i = 0; i < n; i++) begin
      recvByte(d, i < n - 1);
      checkOutput("readData", 32'(d), 32'(match ? expectedRead(i, snap) : 8'hFF));
      if (i == 0) Temperature = 12'($urandom);
    end
    if (!match) checkOutput("quietWhenUnaddressed", 32'(lowSeen), 32'd0);
    stopBit();
    checkOutput("busyAfterStop", 32'(Busy), 32'd0);
    checkOutput("pointer", 32'(Pointer), 32'(modelPointer));
    checkOutput("config", 32'(Config), 32'(modelConfig));
  endtask

  initial begin
    logic b;
    logic [6:0] badAddr;
    int kind;

    waitClk(5);
    Reset = 1'b0;
    waitClk(100);
    checkOutput("resetSdaLow", 32'(SDA_Low), 32'd0);
    checkOutput("resetBusy", 32'(Busy), 32'd0);
    checkOutput("resetPointer", 32'(Pointer), 32'd0);
    checkOutput("resetConfig", 32'(Config), 32'h00);

    Temperature = 12'h190;
    applyStimulusRead(7'h48, 2);

    wrBuf[0] = 8'h01; wrBuf[1] = 8'h60;
    applyStimulusWrite(7'h48, 2, 1'b1);
    applyStimulusRead(7'h48, 1);

    wrBuf[0] = 8'h00;
    applyStimulusWrite(7'h49, 1, 1'b1);

    wrBuf[0] = 8'h00;
    applyStimulusWrite(7'h48, 1, 1'b0);
    Temperature = 12'hE70;
    applyStimulusRead(7'h48, 2);

    // Reset in the middle of a read byte while the responder is pulling SDA low.
    wrBuf[0] = 8'h00;
    applyStimulusWrite(7'h48, 1, 1'b1);
    Temperature = 12'h000;
    startBit();
    sendByte(8'h91, b);
    checkOutput("preResetAddrAck", 32'(b), 32'd1);
    for (int i = 0; i < 3; i++) recvBit(b);
    checkOutput("lowBeforeReset", 32'(SDA_Low), 32'd1);
    Reset = 1'b1;
    @(posedge CLOCK);
    #1;
    checkOutput("releaseOnReset", 32'(SDA_Low), 32'd0);
    waitClk(3);
    Reset = 1'b0;
    modelPointer = 2'b00;
    modelConfig = 8'h00;
    waitClk(2 * Q);
    checkOutput("busyAfterReset", 32'(Busy), 32'd0);
    Temperature = 12'($urandom);
    applyStimulusRead(7'h48, 1);

    for (int t = 0; t < 25; t++) begin
      kind = int'($urandom_range(0, 3));
      for (int i = 0; i < 3; i++) wrBuf[i] = 8'($urandom);
      Temperature = 12'($urandom);
      case (kind)
        0: applyStimulusWrite(7'h48, int'($urandom_range(1, 3)), 1'b1);
        1: applyStimulusRead(7'h48, int'($urandom_range(1, 3)));
        2: begin
          do badAddr = 7'($urandom); while (badAddr == 7'h48);
          if ($urandom_range(0, 1) == 0) applyStimulusWrite(badAddr, 2, 1'b1);
          else                           applyStimulusRead(badAddr, 1);
        end
        default: begin
          applyStimulusWrite(7'h48, 1, 1'b0);
          applyStimulusRead(7'h48, int'($urandom_range(1, 3)));
        end
      endcase
    end

    checkOutput("sdaStableWhileSclHigh", 32'(highChanges), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
